// File: rtl/rob_buffer.sv
// Reorder buffer: in-order allocate and retire, out-of-order multi-channel CDB writeback,
// and two operand lookup ports that can see CDB results in the same cycle.
module rob_buffer #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned NUM_CDB = 2
) (
    input  logic                        clk1,
    input  logic                        rst_n,
    input  logic                        alloc_valid,
    input  logic [REG_AW-1:0]           alloc_dest,
    output logic                        alloc_ready,
    output logic [TAG_W-1:0]            alloc_tag,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
    output logic                        commit_valid,
    output logic [TAG_W-1:0]            commit_tag,
    output logic [REG_AW-1:0]           commit_dest,
    output logic [DATA_W-1:0]           commit_data,
    input  logic                        commit_ready,
    input  logic [TAG_W-1:0]            q_tag0,
    input  logic [TAG_W-1:0]            q_tag1,
    output logic                        q_ready0,
    output logic                        q_ready1,
    output logic [DATA_W-1:0]           q_data0,
    output logic [DATA_W-1:0]           q_data1,
    input  logic                        flush,
    output logic [TAG_W:0]              count,
    output logic                        empty,
    output logic                        full
);

    localparam int unsigned CNT_W = TAG_W + 1;

    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  r_done;
    logic [REG_AW-1:0] r_dest  [DEPTH];
    logic [DATA_W-1:0] r_value [DEPTH];
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_full;
    logic              w_alloc;
    logic              w_commit_valid;
    logic              w_commit;
    logic [DEPTH-1:0]  w_wb_hit;
    logic [DATA_W-1:0] w_wb_data [DEPTH];
    logic [TAG_W-1:0]  w_q_tag   [2];
    logic              w_q_hit   [2];
    logic [DATA_W-1:0] w_q_bp    [2];
    logic              w_q_ready [2];
    logic [DATA_W-1:0] w_q_data  [2];

    assign w_full         = (r_count == CNT_W'(DEPTH));
    assign w_alloc        = alloc_valid && !w_full && !flush;
    assign w_commit_valid = r_busy[r_head] && r_done[r_head] && !flush;
    assign w_commit       = w_commit_valid && commit_ready;

    // Per-entry writeback select; channels scanned high to low so the lowest index wins.
    always_comb begin
        for (int e = 0; e < int'(DEPTH); e++) begin
            w_wb_hit[e]  = 1'b0;
            w_wb_data[e] = '0;
            for (int c = int'(NUM_CDB) - 1; c >= 0; c--) begin
                if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == TAG_W'(e))) begin
                    w_wb_hit[e]  = 1'b1;
                    w_wb_data[e] = cdb_data[c*DATA_W +: DATA_W];
                end
            end
            w_wb_hit[e] = w_wb_hit[e] && r_busy[e] && !r_done[e] && !flush;
        end
    end

    assign w_q_tag[0] = q_tag0;
    assign w_q_tag[1] = q_tag1;

    // Operand lookup: stored value when done, else same-cycle CDB bypass.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_q_hit[p] = 1'b0;
            w_q_bp[p]  = '0;
            for (int c = int'(NUM_CDB) - 1; c >= 0; c--) begin
                if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == w_q_tag[p])) begin
                    w_q_hit[p] = 1'b1;
                    w_q_bp[p]  = cdb_data[c*DATA_W +: DATA_W];
                end
            end
            w_q_ready[p] = r_busy[w_q_tag[p]] && (r_done[w_q_tag[p]] || w_q_hit[p]);
            if (!w_q_ready[p]) begin
                w_q_data[p] = '0;
            end else if (r_done[w_q_tag[p]]) begin
                w_q_data[p] = r_value[w_q_tag[p]];
            end else begin
                w_q_data[p] = w_q_bp[p];
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            r_busy  <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int e = 0; e < int'(DEPTH); e++) begin
                r_dest[e]  <= '0;
                r_value[e] <= '0;
            end
        end else if (flush) begin
            r_busy  <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc) begin
                r_busy[r_tail] <= 1'b1;
                r_done[r_tail] <= 1'b0;
                r_dest[r_tail] <= alloc_dest;
                r_tail         <= r_tail + TAG_W'(1);
            end
            for (int e = 0; e < int'(DEPTH); e++) begin
                if (w_wb_hit[e]) begin
                    r_done[e]  <= 1'b1;
                    r_value[e] <= w_wb_data[e];
                end
            end
            // Head is already done, so it can never collide with a writeback.
            if (w_commit) begin
                r_busy[r_head] <= 1'b0;
                r_done[r_head] <= 1'b0;
                r_head         <= r_head + TAG_W'(1);
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign alloc_ready  = !w_full;
    assign alloc_tag    = r_tail;
    assign commit_valid = w_commit_valid;
    assign commit_tag   = r_head;
    assign commit_dest  = r_dest[r_head];
    assign commit_data  = r_value[r_head];
    assign q_ready0     = w_q_ready[0];
    assign q_ready1     = w_q_ready[1];
    assign q_data0      = w_q_data[0];
    assign q_data1      = w_q_data[1];
    assign count        = r_count;
    assign empty        = (r_count == '0);
    assign full         = w_full;

endmodule

// File: tb/tb_rob_buffer.sv
// Directed bench for rob_buffer: a vector table for allocate/writeback/commit/lookup,
// plus hand sequences for full wrap, flush and mid-stream reset.
module tb_rob_buffer;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        alloc_valid;
    logic [3:0]  alloc_dest;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic [1:0]  cdb_valid;
    logic [5:0]  cdb_tag;
    logic [63:0] cdb_data;
    logic        commit_valid;
    logic [2:0]  commit_tag;
    logic [3:0]  commit_dest;
    logic [31:0] commit_data;
    logic        commit_ready;
    logic [2:0]  q_tag0, q_tag1;
    logic        q_ready0, q_ready1;
    logic [31:0] q_data0, q_data1;
    logic        flush;
    logic [3:0]  count;
    logic        empty, full;

    int checks   = 0;
    int failures = 0;

    rob_buffer dut (
        .clk1(clk1), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .commit_valid(commit_valid), .commit_tag(commit_tag),
        .commit_dest(commit_dest), .commit_data(commit_data),
        .commit_ready(commit_ready),
        .q_tag0(q_tag0), .q_tag1(q_tag1),
        .q_ready0(q_ready0), .q_ready1(q_ready1),
        .q_data0(q_data0), .q_data1(q_data1),
        .flush(flush), .count(count), .empty(empty), .full(full)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic        av;
        logic [3:0]  ad;
        logic [1:0]  cv;
        logic [5:0]  ct;
        logic [63:0] cd;
        logic        cr;
        logic [2:0]  q0, q1;
        logic [2:0]  e_atag;
        logic        e_cv;
        logic [2:0]  e_ctag;
        logic [3:0]  e_cdest;
        logic [31:0] e_cdata;
        logic        e_qr0;
        logic [31:0] e_qd0;
        logic        e_qr1;
        logic [31:0] e_qd1;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t v(int av, int ad, int cv, int t1, int t0, int d1, int d0, int cr,
                               int q0, int q1, int atag, int ecv, int ctag, int cdest,
                               int cdata, int qr0, int qd0, int qr1, int qd1, int cnt);
        vec_t r;
        r.av = 1'(av);   r.ad = 4'(ad);   r.cv = 2'(cv);
        r.ct = {3'(t1), 3'(t0)};
        r.cd = {32'(d1), 32'(d0)};
        r.cr = 1'(cr);   r.q0 = 3'(q0);   r.q1 = 3'(q1);
        r.e_atag = 3'(atag);   r.e_cv = 1'(ecv);   r.e_ctag = 3'(ctag);
        r.e_cdest = 4'(cdest); r.e_cdata = 32'(cdata);
        r.e_qr0 = 1'(qr0); r.e_qd0 = 32'(qd0);
        r.e_qr1 = 1'(qr1); r.e_qd1 = 32'(qd1);
        r.e_cnt = 4'(cnt);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        alloc_valid = 1'b0; alloc_dest = '0; cdb_valid = '0; cdb_tag = '0;
        cdb_data = '0; commit_ready = 1'b0; q_tag0 = '0; q_tag1 = '0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic alloc_n(input int n, input int dest_base);
        for (int i = 0; i < n; i++) begin
            alloc_valid = 1'b1;
            alloc_dest  = 4'(dest_base + i);
            tick();
        end
        alloc_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".alloc_ready"},  64'(alloc_ready),  64'd1);
        chk({tag, ".alloc_tag"},    64'(alloc_tag),    64'd0);
        chk({tag, ".commit_valid"}, 64'(commit_valid), 64'd0);
        chk({tag, ".commit_tag"},   64'(commit_tag),   64'd0);
        chk({tag, ".commit_dest"},  64'(commit_dest),  64'd0);
        chk({tag, ".commit_data"},  64'(commit_data),  64'd0);
        chk({tag, ".q_ready0"},     64'(q_ready0),     64'd0);
        chk({tag, ".q_data0"},      64'(q_data0),      64'd0);
        chk({tag, ".q_ready1"},     64'(q_ready1),     64'd0);
        chk({tag, ".count"},        64'(count),        64'd0);
        chk({tag, ".empty"},        64'(empty),        64'd1);
        chk({tag, ".full"},         64'(full),         64'd0);
    endtask

    initial begin
        // Outputs are checked just before the edge that consumes each vector's inputs.
        //         av ad   cv     t1 t0 d1     d0     cr q0 q1 atg cv ctg cdst cdata  qr0 qd0    qr1 qd1    cnt
        vecs[0]  = v(1, 3,  0,     0, 0, 0,     0,     0, 1, 0, 0,  0, 0,  0,   0,     0,  0,     0,  0,     0);
        vecs[1]  = v(1, 5,  0,     0, 0, 0,     0,     0, 1, 0, 1,  0, 0,  3,   0,     0,  0,     0,  0,     1);
        vecs[2]  = v(1, 7,  0,     0, 0, 0,     0,     0, 1, 0, 2,  0, 0,  3,   0,     0,  0,     0,  0,     2);
        vecs[3]  = v(0, 0,  1,     0, 1, 0,     'hAA,  0, 1, 0, 3,  0, 0,  3,   0,     1,  'hAA,  0,  0,     3);
        vecs[4]  = v(0, 0,  2,     0, 0, 'h11,  0,     0, 1, 0, 3,  0, 0,  3,   0,     1,  'hAA,  1,  'h11,  3);
        vecs[5]  = v(0, 0,  0,     0, 0, 0,     0,     1, 1, 0, 3,  1, 0,  3,   'h11,  1,  'hAA,  1,  'h11,  3);
        vecs[6]  = v(0, 0,  0,     0, 0, 0,     0,     1, 1, 0, 3,  1, 1,  5,   'hAA,  1,  'hAA,  0,  0,     2);
        vecs[7]  = v(0, 0,  0,     0, 0, 0,     0,     0, 1, 0, 3,  0, 2,  7,   0,     0,  0,     0,  0,     1);
        vecs[8]  = v(0, 0,  3,     2, 2, 9,     5,     0, 2, 2, 3,  0, 2,  7,   0,     1,  5,     1,  5,     1);
        vecs[9]  = v(0, 0,  0,     0, 0, 0,     0,     0, 2, 3, 3,  1, 2,  7,   5,     1,  5,     0,  0,     1);
        vecs[10] = v(1, 10, 0,     0, 0, 0,     0,     0, 4, 3, 3,  1, 2,  7,   5,     0,  0,     0,  0,     1);
        vecs[11] = v(1, 11, 0,     0, 0, 0,     0,     0, 4, 3, 4,  1, 2,  7,   5,     0,  0,     0,  0,     2);
        vecs[12] = v(0, 0,  2,     4, 0, 'h77,  0,     0, 4, 3, 5,  1, 2,  7,   5,     1,  'h77,  0,  0,     3);
        vecs[13] = v(0, 0,  2,     4, 0, 'h55,  0,     0, 4, 3, 5,  1, 2,  7,   5,     1,  'h77,  0,  0,     3);
        vecs[14] = v(0, 0,  0,     0, 0, 0,     0,     0, 4, 3, 5,  1, 2,  7,   5,     1,  'h77,  0,  0,     3);

        rst_n = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk_reset_outputs("reset");

        for (int i = 0; i < 15; i++) begin
            string n;
            n = $sformatf("vec%0d", i);
            alloc_valid = vecs[i].av; alloc_dest = vecs[i].ad;
            cdb_valid = vecs[i].cv;   cdb_tag = vecs[i].ct;  cdb_data = vecs[i].cd;
            commit_ready = vecs[i].cr; q_tag0 = vecs[i].q0; q_tag1 = vecs[i].q1;
            flush = 1'b0;
            #1;
            chk({n, ".alloc_tag"},    64'(alloc_tag),    64'(vecs[i].e_atag));
            chk({n, ".commit_valid"}, 64'(commit_valid), 64'(vecs[i].e_cv));
            chk({n, ".commit_tag"},   64'(commit_tag),   64'(vecs[i].e_ctag));
            chk({n, ".commit_dest"},  64'(commit_dest),  64'(vecs[i].e_cdest));
            chk({n, ".commit_data"},  64'(commit_data),  64'(vecs[i].e_cdata));
            chk({n, ".q_ready0"},     64'(q_ready0),     64'(vecs[i].e_qr0));
            chk({n, ".q_data0"},      64'(q_data0),      64'(vecs[i].e_qd0));
            chk({n, ".q_ready1"},     64'(q_ready1),     64'(vecs[i].e_qr1));
            chk({n, ".q_data1"},      64'(q_data1),      64'(vecs[i].e_qd1));
            chk({n, ".count"},        64'(count),        64'(vecs[i].e_cnt));
            chk({n, ".empty"},        64'(empty),        64'(vecs[i].e_cnt == 4'd0));
            chk({n, ".full"},         64'(full),         64'(vecs[i].e_cnt == 4'd8));
            chk({n, ".alloc_ready"},  64'(alloc_ready),  64'(vecs[i].e_cnt != 4'd8));
            tick();
        end

        // Fill to full, ignored 9th allocate, then commit and refill across the wrap.
        do_reset();
        alloc_n(8, 0);
        chk("full.full",        64'(full),        64'd1);
        chk("full.alloc_ready", 64'(alloc_ready), 64'd0);
        chk("full.count",       64'(count),       64'd8);
        chk("full.alloc_tag",   64'(alloc_tag),   64'd0);
        alloc_valid = 1'b1; alloc_dest = 4'hF;
        tick();
        chk("full.ninth_count", 64'(count),       64'd8);
        chk("full.ninth_tail",  64'(alloc_tag),   64'd0);
        alloc_valid = 1'b0;
        cdb_valid = 2'b01; cdb_tag = 6'd0; cdb_data = 64'h33;
        tick();
        cdb_valid = '0;
        alloc_valid = 1'b1; alloc_dest = 4'h9; commit_ready = 1'b1;
        #1;
        chk("full.commit_valid", 64'(commit_valid), 64'd1);
        chk("full.commit_data",  64'(commit_data),  64'h33);
        tick();
        commit_ready = 1'b0;
        chk("full.after_commit_count", 64'(count),     64'd7);
        chk("full.after_commit_head",  64'(commit_tag), 64'd1);
        chk("full.alloc_ready_free",   64'(alloc_ready), 64'd1);
        tick();
        alloc_valid = 1'b0;
        chk("full.wrap_count", 64'(count),     64'd8);
        chk("full.wrap_tail",  64'(alloc_tag), 64'd1);
        chk("full.wrap_full",  64'(full),      64'd1);

        // Flush suppresses a ready commit and empties the buffer.
        do_reset();
        alloc_n(5, 1);
        cdb_valid = 2'b01; cdb_tag = 6'd0; cdb_data = 64'h21;
        tick();
        cdb_valid = '0;
        #1;
        chk("flush.pre_commit_valid", 64'(commit_valid), 64'd1);
        commit_ready = 1'b1; flush = 1'b1; alloc_valid = 1'b1;
        #1;
        chk("flush.commit_valid", 64'(commit_valid), 64'd0);
        tick();
        idle();
        #1;
        chk("flush.count",     64'(count),      64'd0);
        chk("flush.empty",     64'(empty),      64'd1);
        chk("flush.alloc_tag", 64'(alloc_tag),  64'd0);
        chk("flush.head",      64'(commit_tag), 64'd0);

        // Mid-stream reset wins over concurrent allocate; next allocation gets tag 0.
        do_reset();
        alloc_n(4, 2);
        cdb_valid = 2'b01; cdb_tag = 6'd0; cdb_data = 64'h44;
        tick();
        cdb_valid = '0;
        #1;
        chk("rst.pre_commit_data", 64'(commit_data), 64'h44);
        rst_n = 1'b0; alloc_valid = 1'b1; alloc_dest = 4'h6;
        tick();
        rst_n = 1'b1;
        idle();
        #1;
        chk_reset_outputs("midrst");
        alloc_valid = 1'b1; alloc_dest = 4'hC;
        #1;
        chk("midrst.alloc_tag", 64'(alloc_tag), 64'd0);
        tick();
        alloc_valid = 1'b0;
        chk("midrst.count",       64'(count),       64'd1);
        chk("midrst.alloc_tag2",  64'(alloc_tag),   64'd1);
        chk("midrst.commit_dest", 64'(commit_dest), 64'hC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
